keccak_word_serializer: RTL and testbench
=========================================

KECCAK_WORD_SERIALIZER -- requirements
Module: keccak_word_serializer

Interface
REQ-001 The block SHALL have parameter IN_W, default 512: width of the captured Keccak state/rate vector.
REQ-002 The block SHALL have parameter WORD_W, default 32: width of one output word; IN_W SHALL be an integer multiple of WORD_W.
REQ-003 The block SHALL derive localparam N = IN_W/WORD_W (word count) and IDX_W = max(1, clog2(N)).
REQ-004 The block SHALL have these ports:
- clk  in  1  clock; single clock domain, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load_i  in  1  capture request.
- data_i  in  IN_W  vector captured on load.
- busy_o  out  1  high while streaming.
- out_valid_o  out  1  stream word valid.
- out_ready_i  in  1  stream consumer ready.
- out_data_o  out  WORD_W  stream word.
- out_idx_o  out  IDX_W  index of the current stream word.
- out_last_o  out  1  current word is word N-1.
- rd_en_i  in  1  random-access read request.
- rd_idx_i  in  IDX_W  random-access word index.
- rd_data_o  out  WORD_W  random-access result.
- rd_err_o  out  1  index out of range.

Function
REQ-005 Word k SHALL be data bits [k*WORD_W+WORD_W-1 : k*WORD_W]; word 0 is the LSBs.
REQ-006 FSM states SHALL be IDLE and STREAM; busy_o = (state == STREAM).
REQ-007 load_i high in any state SHALL, on that edge: buffer <= data_i, idx <= 0, state <= STREAM. A streaming burst in progress is aborted without completion.
REQ-008 In STREAM, out_valid_o SHALL be 1, out_data_o = buffer word[idx], out_idx_o = idx, out_last_o = (idx == N-1). In IDLE all three SHALL be 0.
REQ-009 A transfer occurs when out_valid_o && out_ready_i; idx then increments by 1. out_data_o and out_idx_o SHALL hold stable while valid && !ready.
REQ-010 A transfer with idx == N-1 SHALL return the FSM to IDLE: out_valid_o is 0 the next cycle, idx wraps to 0.
REQ-011 If load_i coincides with any transfer, including the last, load SHALL win: idx = 0, state STREAM. The old word counts as consumed.
REQ-012 First-word latency SHALL be 1 cycle after load_i; sustained throughput SHALL be 1 word/cycle with ready held high, so N cycles per burst.
REQ-013 rd_en_i high SHALL register rd_data_o <= buffer word[rd_idx_i] and rd_err_o <= 0 on the next edge (1-cycle latency). Reads use buffer contents before any same-cycle load.
REQ-014 rd_idx_i >= N with rd_en_i SHALL give rd_data_o = 0 and rd_err_o = 1 for that cycle.
REQ-015 With rd_en_i low, rd_data_o SHALL hold its last value and rd_err_o SHALL return to 0.
REQ-016 The random-access read path SHALL be independent of the FSM and usable in either state without disturbing the stream.

Reset
REQ-017 With rst_n low at an edge: state IDLE, buffer 0, idx 0, rd_data_o 0, rd_err_o 0. All outputs SHALL be 0 after reset.
REQ-018 Reset SHALL override a same-cycle load_i or rd_en_i, and reset mid-burst SHALL discard the burst.

Configuration
REQ-019 With macro KECCAK_SER_BYTESWAP_EN defined, out_data_o and rd_data_o SHALL be byte-reversed within each word. WORD_W SHALL then be a multiple of 8; the bench SHALL fail elaboration otherwise.
REQ-020 Without KECCAK_SER_BYTESWAP_EN, words SHALL pass unmodified. The buffer is never swapped in either case.

Structure
REQ-021 Shared package keccak_pkg SHALL hold KECCAK_WORD_W (32), KECCAK_RATE_W (512) as parameter defaults, and the serializer state enum.
REQ-022 Word selection SHALL be one combinational sub-module, keccak_word_mux (vector, index -> word, out_of_range), instantiated twice: once for the stream and once for the read path.

Verification
REQ-023 Load data_i = {16 words 0x0000000F..0x00000000, word k = k}, ready held 1:
- out_data_o = 0,1,...,15 on consecutive cycles.
- out_last_o high only with data 15.
- busy_o low on the cycle after.
REQ-024 Backpressure: ready toggles 1,0,0,1,... during a burst -> each word held stable while ready is 0, no word skipped or duplicated, 16 transfers total.
REQ-025 Reload: load_i at transfer of word 5, then again coincident with the word-15 transfer -> the stream restarts at new word 0 both times, and busy_o never drops.
REQ-026 Read path: after load, rd_en_i with rd_idx_i = 3 -> rd_data_o = 3 next cycle.
- With IN_W = 480 (N = 15), rd_idx_i = 15 -> rd_data_o = 0, rd_err_o = 1 for one cycle.
REQ-027 Reset: assert rst_n = 0 mid-burst at word 7 -> all outputs 0 next cycle, and no output until the next load_i.
REQ-028 With KECCAK_SER_BYTESWAP_EN, word 0x11223344 SHALL appear as 0x44332211 on both out_data_o and rd_data_o.

Source files
------------

// File: rtl/keccak_word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared definitions for the Keccak word serializer:
//   KECCAK_WORD_W - default output word width
//   KECCAK_RATE_W - default captured state/rate vector width
//   ser_state_e   - serializer FSM state encoding
// -----------------------------------------------------------------------------
package keccak_pkg;

  localparam int unsigned KECCAK_WORD_W = 32;
  localparam int unsigned KECCAK_RATE_W = 512;

  typedef enum logic [0:0] {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_e;

endpackage

// File: rtl/keccak_word_serializer_mux.sv
// -----------------------------------------------------------------------------
// keccak_word_mux
// Combinational word selector: picks word[index] out of a packed vector,
// where word k occupies bits [k*WORD_W +: WORD_W] (word 0 = LSBs).
// Ports:
//   vector       in  IN_W   source vector
//   index        in  IDX_W  word index
//   word         out WORD_W selected word (0 when index is out of range)
//   out_of_range out 1      index >= N
// -----------------------------------------------------------------------------
module keccak_word_mux
  import keccak_pkg::*;
#(
  parameter int unsigned IN_W   = KECCAK_RATE_W,
  parameter int unsigned WORD_W = KECCAK_WORD_W,
  localparam int unsigned N     = IN_W / WORD_W,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IN_W-1:0]   vector,
  input  logic [IDX_W-1:0]  index,
  output logic [WORD_W-1:0] word,
  output logic              out_of_range
);

  // Compare-and-select loop keeps the part-select in range for any index value.
  always_comb begin
    word         = '0;
    out_of_range = (32'(index) >= N);
    for (int unsigned k = 0; k < N; k++) begin
      if (index == IDX_W'(k)) begin
        word = vector[k*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/keccak_word_serializer.sv
// -----------------------------------------------------------------------------
// keccak_word_serializer
// Captures an IN_W-bit Keccak state/rate vector and streams it out as
// N = IN_W/WORD_W words over a valid/ready interface (word 0 first), with an
// independent registered random-access read port into the captured buffer.
// Optional feature macro: KECCAK_SER_BYTESWAP_EN - byte-reverse each output
// word on both the stream and the read port (buffer itself is never swapped).
// Ports:
//   clk          in  1      clock, rising edge
//   rst_n        in  1      synchronous active-low reset
//   load_i       in  1      capture data_i and (re)start the stream
//   data_i       in  IN_W   vector to capture
//   busy_o       out 1      stream in progress
//   out_valid_o  out 1      stream word valid
//   out_ready_i  in  1      stream consumer ready
//   out_data_o   out WORD_W stream word
//   out_idx_o    out IDX_W  index of the current stream word
//   out_last_o   out 1      current word is word N-1
//   rd_en_i      in  1      random-access read request
//   rd_idx_i     in  IDX_W  random-access word index
//   rd_data_o    out WORD_W read result (1-cycle latency, holds when idle)
//   rd_err_o     out 1      read index was out of range
// -----------------------------------------------------------------------------
module keccak_word_serializer
  import keccak_pkg::*;
#(
  parameter int unsigned IN_W   = KECCAK_RATE_W,
  parameter int unsigned WORD_W = KECCAK_WORD_W,
  localparam int unsigned N     = IN_W / WORD_W,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [IN_W-1:0]   data_i,
  output logic              busy_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              out_last_o,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_err_o
);

  localparam logic [0:0]       S_IDLE   = SER_IDLE;
  localparam logic [0:0]       S_STREAM = SER_STREAM;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  // Elaboration-time parameter sanity checks.
  if ((WORD_W == 0) || (IN_W % WORD_W != 0)) begin : g_bad_width
    $error("keccak_word_serializer: IN_W must be a non-zero multiple of WORD_W");
  end
`ifdef KECCAK_SER_BYTESWAP_EN
  if (WORD_W % 8 != 0) begin : g_bad_swap_width
    $error("keccak_word_serializer: byte swap requires WORD_W to be a multiple of 8");
  end
`endif

  logic [0:0]        state_q, state_d;
  logic [IN_W-1:0]   buffer_q, buffer_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] out_data_q;
  logic              out_last_q;
  logic [WORD_W-1:0] rd_data_q;
  logic              rd_err_q;
  logic              xfer;

  logic [WORD_W-1:0] stream_word;
  logic              stream_oor;
  logic [WORD_W-1:0] rd_word;
  logic              rd_oor;

  // Output word formatting: optional byte reversal within the word.
  function automatic logic [WORD_W-1:0] fmt_word(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
`ifdef KECCAK_SER_BYTESWAP_EN
    r = '0;
    for (int unsigned b = 0; b < WORD_W / 8; b++) begin
      r[b*8 +: 8] = w[WORD_W - 8 - b*8 +: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  assign xfer = (state_q == S_STREAM) && out_ready_i;

  // Next-state logic: a load always wins over a same-cycle transfer.
  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    idx_d    = idx_q;
    if (load_i) begin
      buffer_d = data_i;
      idx_d    = '0;
      state_d  = S_STREAM;
    end else if (xfer) begin
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        state_d = S_IDLE;
      end else begin
        idx_d = IDX_W'(idx_q + 1'b1);
      end
    end
  end

  // Stream word is selected from next-state buffer/index so the output can be
  // registered while still appearing one cycle after load.
  keccak_word_mux #(
    .IN_W   (IN_W),
    .WORD_W (WORD_W)
  ) u_stream_mux (
    .vector       (buffer_d),
    .index        (idx_d),
    .word         (stream_word),
    .out_of_range (stream_oor)
  );

  // Read path sees the buffer as it was before any same-cycle load.
  keccak_word_mux #(
    .IN_W   (IN_W),
    .WORD_W (WORD_W)
  ) u_read_mux (
    .vector       (buffer_q),
    .index        (rd_idx_i),
    .word         (rd_word),
    .out_of_range (rd_oor)
  );

  // FSM and capture buffer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      buffer_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      idx_q    <= idx_d;
    end
  end

  // Registered stream word and last flag; both forced to 0 outside a burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else if ((state_d == S_STREAM) && !stream_oor) begin
      out_data_q <= fmt_word(stream_word);
      out_last_q <= (idx_d == IDX_LAST);
    end else begin
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end
  end

  // Random-access read port: data holds when idle, error is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_oor ? '0 : fmt_word(rd_word);
      rd_err_q  <= rd_oor;
    end else begin
      rd_err_q  <= 1'b0;
    end
  end

  assign busy_o      = (state_q == S_STREAM);
  assign out_valid_o = (state_q == S_STREAM);
  assign out_data_o  = out_data_q;
  assign out_idx_o   = idx_q;
  assign out_last_o  = out_last_q;
  assign rd_data_o   = rd_data_q;
  assign rd_err_o    = rd_err_q;

endmodule

// File: tb/tb_keccak_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_keccak_word_serializer
// Self-checking bench for keccak_word_serializer: directed scenarios plus
// randomized traffic, compared every cycle against a queue-based model.
// A second instance with IN_W = 480 (N = 15) exercises out-of-range reads.
// -----------------------------------------------------------------------------
module tb_keccak_word_serializer;

  localparam int unsigned IN_W   = 512;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned N      = IN_W / WORD_W;
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IN_W_B = 480;
  localparam int unsigned N_B    = IN_W_B / WORD_W;
  localparam int unsigned IDX_WB = (N_B > 1) ? $clog2(N_B) : 1;

`ifdef KECCAK_SER_BYTESWAP_EN
  if (WORD_W % 8 != 0) begin : g_bad_swap_width
    $error("tb: byte swap requires WORD_W to be a multiple of 8");
  end
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              load_i;
  logic [IN_W-1:0]   data_i;
  logic              busy_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [WORD_W-1:0] out_data_o;
  logic [IDX_W-1:0]  out_idx_o;
  logic              out_last_o;
  logic              rd_en_i;
  logic [IDX_W-1:0]  rd_idx_i;
  logic [WORD_W-1:0] rd_data_o;
  logic              rd_err_o;

  logic              load_b;
  logic [IN_W_B-1:0] data_b;
  logic              busy_b;
  logic              valid_b;
  logic              ready_b;
  logic [WORD_W-1:0] data_out_b;
  logic [IDX_WB-1:0] idx_b;
  logic              last_b;
  logic              rd_en_b;
  logic [IDX_WB-1:0] rd_idx_b;
  logic [WORD_W-1:0] rd_data_b;
  logic              rd_err_b;

  keccak_word_serializer #(.IN_W(IN_W), .WORD_W(WORD_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_i),
    .data_i      (data_i),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o),
    .out_last_o  (out_last_o),
    .rd_en_i     (rd_en_i),
    .rd_idx_i    (rd_idx_i),
    .rd_data_o   (rd_data_o),
    .rd_err_o    (rd_err_o)
  );

  keccak_word_serializer #(.IN_W(IN_W_B), .WORD_W(WORD_W)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_b),
    .data_i      (data_b),
    .busy_o      (busy_b),
    .out_valid_o (valid_b),
    .out_ready_i (ready_b),
    .out_data_o  (data_out_b),
    .out_idx_o   (idx_b),
    .out_last_o  (last_b),
    .rd_en_i     (rd_en_b),
    .rd_idx_i    (rd_idx_b),
    .rd_data_o   (rd_data_b),
    .rd_err_o    (rd_err_b)
  );

  int checks;
  int errors;

  // Reference model: captured words, queue of words still to be streamed,
  // and the last read-port result.
  logic [WORD_W-1:0] m_buf [N];
  logic [WORD_W-1:0] m_q [$];
  logic [WORD_W-1:0] m_rd;
  logic              m_rd_err;

  // Words actually accepted from the DUT stream.
  logic [WORD_W-1:0] got_q [$];
  logic              watch_busy;
  logic              busy_dropped;

  function automatic logic [WORD_W-1:0] swp(input logic [WORD_W-1:0] w);
`ifdef KECCAK_SER_BYTESWAP_EN
    logic [WORD_W-1:0] r;
    for (int b = 0; b < int'(WORD_W / 8); b++) r[b*8 +: 8] = w[WORD_W - 8 - b*8 +: 8];
    return r;
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic step();
    if (rst_n && out_valid_o && out_ready_i) got_q.push_back(out_data_o);
    if (!rst_n) begin
      m_q.delete();
      for (int k = 0; k < int'(N); k++) m_buf[k] = '0;
      m_rd     = '0;
      m_rd_err = 1'b0;
    end else begin
      if (rd_en_i) begin
        if (int'(rd_idx_i) >= int'(N)) begin
          m_rd     = '0;
          m_rd_err = 1'b1;
        end else begin
          m_rd     = swp(m_buf[rd_idx_i]);
          m_rd_err = 1'b0;
        end
      end else begin
        m_rd_err = 1'b0;
      end
      if (m_q.size() > 0 && out_ready_i) void'(m_q.pop_front());
      if (load_i) begin
        m_q.delete();
        for (int k = 0; k < int'(N); k++) begin
          m_buf[k] = data_i[k*WORD_W +: WORD_W];
          m_q.push_back(m_buf[k]);
        end
      end
    end
    @(posedge clk);
    #1;
    check("busy",    64'(busy_o),      64'(m_q.size() > 0));
    check("valid",   64'(out_valid_o), 64'(m_q.size() > 0));
    check("data",    64'(out_data_o),  (m_q.size() > 0) ? 64'(swp(m_q[0])) : 64'(0));
    check("idx",     64'(out_idx_o),   (m_q.size() > 0) ? 64'(int'(N) - m_q.size()) : 64'(0));
    check("last",    64'(out_last_o),  64'(m_q.size() == 1));
    check("rd_data", 64'(rd_data_o),   64'(m_rd));
    check("rd_err",  64'(rd_err_o),    64'(m_rd_err));
    if (watch_busy && !busy_o) busy_dropped = 1'b1;
  endtask

  task automatic make_vec(input int base, output logic [IN_W-1:0] v);
    for (int k = 0; k < int'(N); k++) v[k*WORD_W +: WORD_W] = WORD_W'(base + k);
  endtask

  task automatic make_rand(output logic [IN_W-1:0] v);
    for (int k = 0; k < int'(N); k++) v[k*WORD_W +: WORD_W] = WORD_W'($urandom);
  endtask

  task automatic run_to_idx(input int t);
    int n = 0;
    while (!(out_valid_o && out_idx_o == IDX_W'(t)) && n < 100) begin
      step();
      n++;
    end
    check("reach_idx", 64'(out_valid_o && out_idx_o == IDX_W'(t)), 64'(1));
  endtask

  task automatic run_to_idle();
    int n = 0;
    while (busy_o && n < 200) begin
      step();
      n++;
    end
    check("reach_idle", 64'(busy_o), 64'(0));
  endtask

  task automatic check_burst(input string tag, input int base);
    check({tag, "_count"}, 64'(got_q.size()), 64'(N));
    for (int k = 0; k < got_q.size() && k < int'(N); k++)
      check({tag, "_word"}, 64'(got_q[k]), 64'(swp(WORD_W'(base + k))));
  endtask

  initial begin
    logic [IN_W-1:0]   v;
    logic [IN_W_B-1:0] vb;
    int c;

    checks = 0;
    errors = 0;
    watch_busy = 1'b0;
    busy_dropped = 1'b0;
    rst_n = 1'b0; load_i = 1'b0; data_i = '0; out_ready_i = 1'b0;
    rd_en_i = 1'b0; rd_idx_i = '0;
    load_b = 1'b0; data_b = '0; ready_b = 1'b1; rd_en_b = 1'b0; rd_idx_b = '0;
    for (int k = 0; k < int'(N); k++) m_buf[k] = '0;
    m_rd = '0;
    m_rd_err = 1'b0;

    // Reset overrides a same-cycle load and read.
    step();
    make_vec(0, v);
    data_i = v; load_i = 1'b1; rd_en_i = 1'b1; rd_idx_i = IDX_W'(3);
    step();
    load_i = 1'b0; rd_en_i = 1'b0;
    rst_n = 1'b1;
    step();

    // Basic burst, ready held high.
    got_q.delete();
    out_ready_i = 1'b1;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    check("first_word", 64'(out_data_o), 64'(swp(WORD_W'(0))));
    run_to_idle();
    check_burst("basic", 0);

    // Read path after load: index 3.
    rd_en_i = 1'b1; rd_idx_i = IDX_W'(3);
    step();
    rd_en_i = 1'b0;
    check("rd3", 64'(rd_data_o), 64'(swp(WORD_W'(3))));
    step();
    check("rd_hold", 64'(rd_data_o), 64'(swp(WORD_W'(3))));

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    got_q.delete();
    make_vec(32, v);
    data_i = v; load_i = 1'b1; out_ready_i = 1'b0;
    step();
    load_i = 1'b0;
    c = 0;
    while (busy_o && c < 200) begin
      out_ready_i = (c % 3 == 0);
      step();
      c++;
    end
    check("bp_idle", 64'(busy_o), 64'(0));
    check_burst("bp", 32);

    // Reload at word 5, then again coincident with the word-15 transfer.
    out_ready_i = 1'b1;
    make_vec(64, v);
    data_i = v; load_i = 1'b1;
    step();
    load_i = 1'b0;
    watch_busy = 1'b1;
    run_to_idx(5);
    make_vec(100, v);
    data_i = v; load_i = 1'b1;
    step();
    load_i = 1'b0;
    check("reload1_w0", 64'(out_data_o), 64'(swp(WORD_W'(100))));
    run_to_idx(15);
    check("last_at_15", 64'(out_last_o), 64'(1));
    make_vec(200, v);
    data_i = v; load_i = 1'b1;
    step();
    load_i = 1'b0;
    check("reload2_w0", 64'(out_data_o), 64'(swp(WORD_W'(200))));
    got_q.delete();
    run_to_idx(15);
    watch_busy = 1'b0;
    check("busy_never_dropped", 64'(busy_dropped), 64'(0));
    run_to_idle();

    // Reset mid-burst at word 7 discards the burst.
    make_vec(300, v);
    data_i = v; load_i = 1'b1;
    step();
    load_i = 1'b0;
    run_to_idx(7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_valid", 64'(out_valid_o), 64'(0));
    check("rst_data",  64'(out_data_o),  64'(0));
    repeat (4) step();

    // Out-of-range read on the N = 15 instance.
    for (int k = 0; k < int'(N_B); k++) vb[k*WORD_W +: WORD_W] = WORD_W'(k);
    data_b = vb; load_b = 1'b1;
    step();
    load_b = 1'b0;
    rd_en_b = 1'b1; rd_idx_b = IDX_WB'(15);
    step();
    check("oor_data", 64'(rd_data_b), 64'(0));
    check("oor_err",  64'(rd_err_b),  64'(1));
    rd_en_b = 1'b0;
    step();
    check("oor_err_clr", 64'(rd_err_b), 64'(0));
    rd_en_b = 1'b1; rd_idx_b = IDX_WB'(14);
    step();
    rd_en_b = 1'b0;
    check("b_rd14",     64'(rd_data_b), 64'(swp(WORD_W'(14))));
    check("b_rd14_err", 64'(rd_err_b),  64'(0));

`ifdef KECCAK_SER_BYTESWAP_EN
    // Byte reversal on both output paths.
    v = '0;
    v[WORD_W-1:0] = 32'h1122_3344;
    data_i = v; load_i = 1'b1; out_ready_i = 1'b0;
    step();
    load_i = 1'b0;
    check("swap_stream", 64'(out_data_o), 64'h4433_2211);
    rd_en_i = 1'b1; rd_idx_i = '0;
    step();
    rd_en_i = 1'b0;
    check("swap_read", 64'(rd_data_o), 64'h4433_2211);
    out_ready_i = 1'b1;
    run_to_idle();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst_n       = ($urandom_range(199) != 0);
      load_i      = ($urandom_range(15) == 0);
      if (load_i) begin
        make_rand(v);
        data_i = v;
      end
      out_ready_i = ($urandom_range(3) != 0);
      rd_en_i     = ($urandom_range(1) == 1);
      rd_idx_i    = IDX_W'($urandom_range(N - 1));
      step();
    end
    rst_n = 1'b1; load_i = 1'b0; rd_en_i = 1'b0; out_ready_i = 1'b1;
    run_to_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
